// File: rtl/serializador_morse.sv
// Serialises one captured ASCII character onto a Morse key line with ITU timing
// (dot = 1 unit, dash = 3, element gap = 1, letter gap = 3, word space = 7).
module serializador_morse #(
    parameter int UNIT_CYCLES = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] caracter,
    input  logic       cargar,
    output logic       morse,
    output logic       listo,
    output logic       fin,
    output logic       error
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] CICLO_MAX = CW'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        MARCA         = 3'd1,
        PAUSA_SIMBOLO = 3'd2,
        PAUSA_LETRA   = 3'd3,
        PALABRA       = 3'd4
    } estado_t;

    // Returns {valid, length, pattern}; pattern is left-aligned so element i is bit 4-i.
    function automatic logic [8:0] buscar(input logic [7:0] c);
        logic [7:0] u;
        logic [7:0] lp;
        logic       v;
        u  = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
        v  = 1'b1;
        lp = 8'h00;
        case (u)
            8'h41: lp = 8'b010_00001;
            8'h42: lp = 8'b100_01000;
            8'h43: lp = 8'b100_01010;
            8'h44: lp = 8'b011_00100;
            8'h45: lp = 8'b001_00000;
            8'h46: lp = 8'b100_00010;
            8'h47: lp = 8'b011_00110;
            8'h48: lp = 8'b100_00000;
            8'h49: lp = 8'b010_00000;
            8'h4A: lp = 8'b100_00111;
            8'h4B: lp = 8'b011_00101;
            8'h4C: lp = 8'b100_00100;
            8'h4D: lp = 8'b010_00011;
            8'h4E: lp = 8'b010_00010;
            8'h4F: lp = 8'b011_00111;
            8'h50: lp = 8'b100_00110;
            8'h51: lp = 8'b100_01101;
            8'h52: lp = 8'b011_00010;
            8'h53: lp = 8'b011_00000;
            8'h54: lp = 8'b001_00001;
            8'h55: lp = 8'b011_00001;
            8'h56: lp = 8'b100_00001;
            8'h57: lp = 8'b011_00011;
            8'h58: lp = 8'b100_01001;
            8'h59: lp = 8'b100_01011;
            8'h5A: lp = 8'b100_01100;
            8'h30: lp = 8'b101_11111;
            8'h31: lp = 8'b101_01111;
            8'h32: lp = 8'b101_00111;
            8'h33: lp = 8'b101_00011;
            8'h34: lp = 8'b101_00001;
            8'h35: lp = 8'b101_00000;
            8'h36: lp = 8'b101_10000;
            8'h37: lp = 8'b101_11000;
            8'h38: lp = 8'b101_11100;
            8'h39: lp = 8'b101_11110;
            default: v = 1'b0;
        endcase
        return {v, lp[7:5], lp[4:0] << (3'd5 - lp[7:5])};
    endfunction

    estado_t       r_estado;
    estado_t       w_estado_sig;
    logic [CW-1:0] r_ciclo;
    logic [2:0]    r_unidad;
    logic [2:0]    r_elem;
    logic [2:0]    r_long;
    logic [4:0]    r_patron;
    logic          r_morse;
    logic          r_listo;
    logic          r_fin;
    logic          r_error;

    logic [8:0]    w_busqueda;
    logic          w_valido;
    logic          w_espacio;
    logic          w_acepta;
    logic          w_raya;
    logic [2:0]    w_dur;
    logic          w_fin_unidad;
    logic          w_fin_estado;
    logic          w_fin_sig;
    logic          w_err_sig;

    assign w_busqueda   = buscar(caracter);
    assign w_valido     = w_busqueda[8];
    assign w_espacio    = (caracter == 8'h20);
    assign w_acepta     = (r_estado == IDLE) && cargar;
    assign w_raya       = r_patron[3'd4 - r_elem];
    assign w_fin_unidad = (r_ciclo == CICLO_MAX);
    assign w_fin_estado = w_fin_unidad && (r_unidad == w_dur);

    // Duration of the current state, in units minus one.
    always_comb begin
        w_dur = 3'd0;
        case (r_estado)
            MARCA:         w_dur = w_raya ? 3'd2 : 3'd0;
            PAUSA_SIMBOLO: w_dur = 3'd0;
            PAUSA_LETRA:   w_dur = 3'd2;
            PALABRA:       w_dur = 3'd6;
            default:       w_dur = 3'd0;
        endcase
    end

    // Next-state logic plus the one-cycle fin/error requests.
    always_comb begin
        w_estado_sig = r_estado;
        w_fin_sig    = 1'b0;
        w_err_sig    = 1'b0;
        case (r_estado)
            IDLE: begin
                if (cargar) begin
                    if (w_valido) begin
                        w_estado_sig = MARCA;
                    end else if (w_espacio) begin
                        w_estado_sig = PALABRA;
                    end else begin
                        w_err_sig = 1'b1;
                    end
                end else begin
                    w_estado_sig = IDLE;
                end
            end
            MARCA: begin
                if (w_fin_estado) begin
                    if ((r_elem + 3'd1) < r_long) begin
                        w_estado_sig = PAUSA_SIMBOLO;
                    end else begin
                        w_estado_sig = PAUSA_LETRA;
                    end
                end else begin
                    w_estado_sig = MARCA;
                end
            end
            PAUSA_SIMBOLO: begin
                if (w_fin_estado) begin
                    w_estado_sig = MARCA;
                end else begin
                    w_estado_sig = PAUSA_SIMBOLO;
                end
            end
            PAUSA_LETRA, PALABRA: begin
                if (w_fin_estado) begin
                    w_estado_sig = IDLE;
                    w_fin_sig    = 1'b1;
                end else begin
                    w_estado_sig = r_estado;
                end
            end
            default: w_estado_sig = IDLE;
        endcase
    end

    // State register and registered outputs, driven from the next state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_estado <= IDLE;
            r_morse  <= 1'b0;
            r_listo  <= 1'b1;
            r_fin    <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_morse  <= (w_estado_sig == MARCA);
            r_listo  <= (w_estado_sig == IDLE);
            r_fin    <= w_fin_sig;
            r_error  <= w_err_sig;
        end
    end

    // Cycle and unit counters restart on every state entry and stay cleared in IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ciclo  <= '0;
            r_unidad <= 3'd0;
        end else if ((w_estado_sig != r_estado) || (r_estado == IDLE)) begin
            r_ciclo  <= '0;
            r_unidad <= 3'd0;
        end else if (w_fin_unidad) begin
            r_ciclo  <= '0;
            r_unidad <= r_unidad + 3'd1;
        end else begin
            r_ciclo  <= r_ciclo + CW'(1);
            r_unidad <= r_unidad;
        end
    end

    // Character capture on accept; element index advances when a mark ends with more to come.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_elem   <= 3'd0;
            r_long   <= 3'd0;
            r_patron <= 5'd0;
        end else if (w_acepta) begin
            r_elem   <= 3'd0;
            r_long   <= w_busqueda[7:5];
            r_patron <= w_busqueda[4:0];
        end else if ((r_estado == MARCA) && (w_estado_sig == PAUSA_SIMBOLO)) begin
            r_elem   <= r_elem + 3'd1;
        end else begin
            r_elem   <= r_elem;
        end
    end

    assign morse = r_morse;
    assign listo = r_listo;
    assign fin   = r_fin;
    assign error = r_error;

endmodule

// File: doc/serializador_morse.md
# serializador_morse

Consumes the 8-bit ASCII character held by the parallel-in/parallel-out character register and serialises it onto a single Morse keying line using standard ITU timing. Sits directly downstream of the character register and drives the transmitter key output. One character per `cargar` handshake; `fin` tells the upstream control that the register may be reloaded.

## Interface

Parameters:
- `UNIT_CYCLES`, default 5: CLK cycles per Morse time unit, valid range ≥1. Use 5 in simulation; the board top overrides it.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset, asynchronous and active-low (0 = reset).
- `caracter`  in  8  ASCII code from the character register output.
- `cargar`  in  1  start request, sampled only while `listo`=1.
- `morse`  out  1  key line: 1 = carrier on (mark), 0 = off.
- `listo`  out  1  idle; a new character may be accepted.
- `fin`  out  1  one-cycle pulse when a character, including its trailing gap, is complete.
- `error`  out  1  one-cycle pulse when an unsupported code is requested.

## Operation

Supported codes:
- 0x41–0x5A (A–Z) and 0x61–0x7A (a–z) map case-insensitively to ITU letters.
- 0x30–0x39 map to digits; every digit has 5 elements.
- 0x20 is a word space.
- Every other code is invalid.

Lookup and capture:
- Combinational lookup returns a length of 1–5 and a pattern, MSB first, with 1 = dash.
- `caracter` is captured internally on the accept edge. Later changes on `caracter` have no effect until the next accept.

State machine, all outputs registered:
- IDLE: `listo`=1, `morse`=0.
  - `cargar`=1 with a valid letter or digit: go to MARCA with the first element.
  - `cargar`=1 with 0x20: go to PALABRA.
  - `cargar`=1 with an invalid code: stay in IDLE; `error`=1 for the next cycle; `fin` is not pulsed.
- MARCA: `morse`=1 for 1 unit (dot) or 3 units (dash). Then go to PAUSA_SIMBOLO if elements remain, else to PAUSA_LETRA.
- PAUSA_SIMBOLO: `morse`=0 for 1 unit, then MARCA with the next element.
- PAUSA_LETRA: `morse`=0 for 3 units, then IDLE with `fin` pulsed.
- PALABRA: `morse`=0 for 7 units, then IDLE with `fin` pulsed.

Counters:
- A cycle counter of width ⌈log2(UNIT_CYCLES)⌉ (min 1) with terminal value UNIT_CYCLES−1.
- A unit counter of 3 bits, max 7.
- An element index of 3 bits.
- No counter wraps inside a state; each counter reloads to 0 on every state entry.

`cargar` is ignored while `listo`=0 and is never queued.

## Timing

Reset:
- While `RST`=0, asynchronously: `morse`=0, `listo`=1, `fin`=0, `error`=0, state IDLE, all counters 0.
- Reset asserted mid-character drops `morse` immediately; no `fin` is produced.

Accept and output timing (U = UNIT_CYCLES, accept edge = edge 0):
- `listo` falls and `morse` rises in the cycle after edge 0, i.e. latency 1.
- Mark and gap durations are exact multiples of U cycles with no extra bubble cycles between states.
- Character busy time = Σ(marks) + (n−1)·U + 3U; for a space it is 7U.
- `fin` and `listo` both rise at edge 0 + busy time. `fin` lasts exactly one cycle.
- `cargar`=1 in that same `fin` cycle is accepted, giving back-to-back characters with exactly a 3U letter gap.

Invalid codes:
- `error` is high in the cycle after the request edge.
- `listo` stays 1 throughout, so a new `cargar` on the next edge is accepted.

## Test plan

All scenarios use UNIT_CYCLES=5, `RST` low for 30 ns, CLK period 10 ns.

1. `caracter`=0x45 ('E'), one-cycle `cargar` → `morse` high 5 cycles, then low 15; `fin` pulse 20 cycles after accept; `listo` low for exactly 20 cycles.
2. 0x41 ('A') → `morse` pattern 5 high / 5 low / 15 high / 15 low; `fin` at 40 cycles. Repeat with 0x61: the waveform must be identical.
3. 0x30 ('0'), with `caracter` changed to 0xFF one cycle after accept → five 15-cycle marks separated by 5-cycle gaps, then 15 low; `fin` at 110 cycles; no `error`.
4. 0x20 → `morse` stays 0; `listo` low for 35 cycles; `fin` at 35. Then 0x3F ('?') → `error` pulse 1 cycle, `listo` stays 1, `morse` stays 0, no `fin`.
5. 'E' with `cargar` held high continuously:
   - `cargar` is ignored while busy.
   - The next accept occurs in the `fin` cycle, so `morse` is periodic: 5 high, 15 low.
6. Reset mid-character: drive `RST` low 12 cycles into the first dash of 'A' (0x41) → `morse`=0 and `listo`=1 immediately, with no `fin`. After release, 0x45 serialises normally, as in scenario 1.
